drp_reconfig_sequencer: RTL and testbench



---
 rtl/drp_reconfig_sequencer_if.sv | 34 +++
 rtl/drp_reconfig_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_drp_reconfig_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/drp_reconfig_sequencer_if.sv
// drp_reconfig_sequencer_if
//   Bundles the sample input, the DRP controller handshake and the status
//   outputs of the reconfiguration sequencer.
//   master : the sequencer (drives freq_mode/drp_start/status)
//   slave  : the environment (measurement block + DRP controller)
//   count_val/count_vld : windowed DCO edge count and its 1-cycle qualifier
//   srdy                : 1-cycle ready pulse from the DRP controller
//   freq_mode           : applied range code 1..5, 0 = none
//   drp_start           : 1-cycle reconfiguration strobe
//   data_clk_rdy        : MMCM reconfigured for the current range
//   seq_busy            : reconfiguration in flight
//   retry_err           : sticky, retries exhausted
interface drp_reconfig_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] count_val;
  logic             count_vld;
  logic             srdy;
  logic [2:0]       freq_mode;
  logic             drp_start;
  logic             data_clk_rdy;
  logic             seq_busy;
  logic             retry_err;

  modport master (
    input  count_val, count_vld, srdy,
    output freq_mode, drp_start, data_clk_rdy, seq_busy, retry_err
  );

  modport slave (
    output count_val, count_vld, srdy,
    input  freq_mode, drp_start, data_clk_rdy, seq_busy, retry_err
  );
endinterface

// File: rtl/drp_reconfig_sequencer.sv
// drp_reconfig_sequencer
//   Classifies windowed DCO edge counts into frequency ranges 1..5 (with
//   hysteresis around the applied range and a consecutive-sample stability
//   filter), strobes the MMCM DRP controller with the new range code, waits
//   for its ready pulse and reports data clock readiness. Re-tunes whenever
//   the DCO settles in a different range.
//   Ports:
//     drp_refclk : sole clock
//     reset      : synchronous, active-high
//     bus        : drp_reconfig_sequencer_if.master (samples, srdy, status)
//   Optional feature macro: DRP_SEQ_TIMEOUT_EN
//     defined   -> srdy timeout, retry counter and sticky ERROR state
//     undefined -> WAIT_RDY waits forever, retry_err tied low
module drp_reconfig_sequencer #(
  parameter int CNT_W       = 16,
  parameter int R1_CNT      = 350,
  parameter int R2_CNT      = 700,
  parameter int R3_CNT      = 1550,
  parameter int R4_CNT      = 3300,
  parameter int HYST_CNT    = 16,
  parameter int STABLE_N    = 3,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 3
) (
  input  logic                      drp_refclk,
  input  logic                      reset,
  drp_reconfig_sequencer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, START, WAIT_RDY, LOCKED, ERROR} state_t;
  state_t state, state_nxt;

  // Bounds are one bit wider than the sample so +HYST cannot wrap.
  localparam int BW = CNT_W + 1;
  typedef logic [BW-1:0] bnd_t;

  // Inclusive upper bound of range m (range 5 unbounded).
  function automatic bnd_t upper(input logic [2:0] m);
    case (m)
      3'd1:    upper = bnd_t'(R1_CNT);
      3'd2:    upper = bnd_t'(R2_CNT);
      3'd3:    upper = bnd_t'(R3_CNT);
      3'd4:    upper = bnd_t'(R4_CNT);
      default: upper = '1;
    endcase
  endfunction

  // Exclusive lower bound of range m (range 1 starts at 0).
  function automatic bnd_t lower(input logic [2:0] m);
    case (m)
      3'd2:    lower = bnd_t'(R1_CNT);
      3'd3:    lower = bnd_t'(R2_CNT);
      3'd4:    lower = bnd_t'(R3_CNT);
      3'd5:    lower = bnd_t'(R4_CNT);
      default: lower = '0;
    endcase
  endfunction

  // Raw range, overridden by the applied range m when the sample sits
  // inside m's band widened by HYST_CNT on both sides.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] c,
                                          input logic [2:0] m);
    bnd_t       cx, lo, hi;
    logic [2:0] r;
    cx = bnd_t'(c);
    if      (cx <= bnd_t'(R1_CNT)) r = 3'd1;
    else if (cx <= bnd_t'(R2_CNT)) r = 3'd2;
    else if (cx <= bnd_t'(R3_CNT)) r = 3'd3;
    else if (cx <= bnd_t'(R4_CNT)) r = 3'd4;
    else                           r = 3'd5;
    if (m != 3'd0) begin
      lo = (lower(m) >= bnd_t'(HYST_CNT)) ? lower(m) - bnd_t'(HYST_CNT) : '0;
      hi = (m == 3'd5) ? '1 : upper(m) + bnd_t'(HYST_CNT);
      if (cx > lo && cx <= hi) r = m;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Classification + stability filter
  // ---------------------------------------------------------------------
  logic [2:0] mode_q, cls, cand;
  logic [3:0] stab_cnt, stab_nxt;
  logic       listen, accept, qual, go_q;

  always_comb begin
    listen = (state == IDLE) || (state == LOCKED);
    accept = bus.count_vld && listen;
    cls    = classify(bus.count_val, mode_q);
    if (cls == cand && stab_cnt != 4'd0)
      stab_nxt = (stab_cnt == 4'(STABLE_N)) ? stab_cnt : stab_cnt + 4'd1;
    else
      stab_nxt = 4'd1;
    // go_q guards the one cycle between loading freq_mode and START so a
    // further sample cannot re-trigger. In LOCKED only a different range
    // counts as a new qualification.
    qual = accept && !go_q && (stab_nxt == 4'(STABLE_N)) &&
           ((state == IDLE) || (cls != mode_q));
  end

  // freq_mode is loaded one cycle ahead of START; go_q then moves the FSM.
  always_ff @(posedge drp_refclk) begin
    if (reset) begin
      mode_q   <= 3'd0;
      go_q     <= 1'b0;
      cand     <= 3'd0;
      stab_cnt <= 4'd0;
    end else begin
      go_q <= qual;
      if (qual) mode_q <= cls;
      if (!listen) begin
        cand     <= 3'd0;
        stab_cnt <= 4'd0;
      end else if (accept) begin
        cand     <= cls;
        stab_cnt <= stab_nxt;
      end
    end
  end

  assign bus.freq_mode = mode_q;

  // ---------------------------------------------------------------------
  // srdy timeout / retry
  // ---------------------------------------------------------------------
`ifdef DRP_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [TW-1:0] timer;
  logic [RW-1:0] retries;
  logic          timeout, can_retry;

  assign timeout   = (timer == TW'(TIMEOUT_CYC - 1));
  assign can_retry = (retries < RW'(MAX_RETRY));

  always_ff @(posedge drp_refclk) begin
    if (reset) begin
      timer   <= '0;
      retries <= '0;
    end else begin
      // Runs only in WAIT_RDY, so it is zero on the first WAIT_RDY cycle.
      timer <= (state == WAIT_RDY) ? timer + TW'(1) : '0;
      if (state == LOCKED)
        retries <= '0;
      else if (state == WAIT_RDY && !bus.srdy && timeout && can_retry)
        retries <= retries + RW'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge drp_refclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.drp_start    = 1'b0;
    bus.seq_busy     = 1'b0;
    bus.data_clk_rdy = 1'b0;
    bus.retry_err    = 1'b0;
    case (state)
      IDLE: if (go_q) state_nxt = START;
      START: begin
        bus.drp_start = 1'b1;
        bus.seq_busy  = 1'b1;
        state_nxt     = WAIT_RDY;
      end
      WAIT_RDY: begin
        bus.seq_busy = 1'b1;
        // srdy has priority over a coincident timeout.
        if (bus.srdy) state_nxt = LOCKED;
`ifdef DRP_SEQ_TIMEOUT_EN
        else if (timeout) state_nxt = can_retry ? START : ERROR;
`endif
      end
      LOCKED: begin
        // Ready drops together with the freq_mode change of a re-tune.
        bus.data_clk_rdy = !go_q;
        if (go_q) state_nxt = START;
      end
      ERROR: begin
`ifdef DRP_SEQ_TIMEOUT_EN
        bus.retry_err = 1'b1;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_drp_reconfig_sequencer.sv
// tb_drp_reconfig_sequencer
//   Directed vector table (one row per clock: inputs + expected outputs
//   after the edge) followed by hand-written timeout / retry sequences.
module tb_drp_reconfig_sequencer;
  localparam int CNT_W = 16;

  logic drp_refclk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  drp_reconfig_sequencer_if #(.CNT_W(CNT_W)) bus ();

  drp_reconfig_sequencer #(.CNT_W(CNT_W)) dut (
    .drp_refclk (drp_refclk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 drp_refclk = ~drp_refclk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] cnt;
    logic        srdy;
    logic [2:0]  mode;
    logic        start;
    logic        rdy;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function void add(input logic rst, input logic vld, input logic [15:0] cnt,
                    input logic srdy, input logic [2:0] mode, input logic start,
                    input logic rdy, input logic busy, input logic err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.cnt = cnt; v.srdy = srdy;
    v.mode = mode; v.start = start; v.rdy = rdy; v.busy = busy; v.err = err;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge drp_refclk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [15:0] cnt,
                       input logic srdy);
    reset         = rst;
    bus.count_vld = vld;
    bus.count_val = cnt;
    bus.srdy      = srdy;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 16'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  // Three consecutive qualifying samples, then inputs idle.
  task automatic feed3(input logic [15:0] cnt);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, cnt, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic wait_start(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (bus.drp_start === 1'b1) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int pulses, last;
    drive(1'b1, 1'b0, 16'd0, 1'b0);

    // rst vld cnt srdy | mode start rdy busy err
    add(1,0,   0,0, 0,0,0,0,0);
    // first lock in range 3
    add(0,1,1000,0, 0,0,0,0,0);
    add(0,1,1000,0, 0,0,0,0,0);
    add(0,1,1000,0, 3,0,0,0,0);
    add(0,0,   0,0, 3,1,0,1,0);
    add(0,0,   0,0, 3,0,0,1,0);
    add(0,0,   0,1, 3,0,1,0,0);
    // inside upper hysteresis band of 3 (<=1566)
    add(0,1,1560,0, 3,0,1,0,0);
    add(0,1,1560,0, 3,0,1,0,0);
    add(0,1,1560,0, 3,0,1,0,0);
    add(0,0,   0,0, 3,0,1,0,0);
    // beyond the band: re-tune to 4
    add(0,1,1570,0, 3,0,1,0,0);
    add(0,1,1570,0, 3,0,1,0,0);
    add(0,1,1570,0, 4,0,0,0,0);
    add(0,0,   0,0, 4,1,0,1,0);
    add(0,0,   0,0, 4,0,0,1,0);
    add(0,0,   0,1, 4,0,1,0,0);
    // inside lower band of 4 (>1534)
    add(0,1,1540,0, 4,0,1,0,0);
    add(0,1,1540,0, 4,0,1,0,0);
    add(0,1,1540,0, 4,0,1,0,0);
    // exactly on the lower band edge: back to 3
    add(0,1,1534,0, 4,0,1,0,0);
    add(0,1,1534,0, 4,0,1,0,0);
    add(0,1,1534,0, 3,0,0,0,0);
    add(0,0,   0,0, 3,1,0,1,0);
    add(0,0,   0,0, 3,0,0,1,0);
    // reset while in WAIT_RDY: everything clears, no drp_start follows
    add(1,0,   0,0, 0,0,0,0,0);
    add(0,0,   0,0, 0,0,0,0,0);
    add(0,0,   0,0, 0,0,0,0,0);
    // threshold value belongs to the lower range
    add(0,1, 350,0, 0,0,0,0,0);
    add(0,1, 350,0, 0,0,0,0,0);
    add(0,1, 350,0, 1,0,0,0,0);
    add(0,0,   0,0, 1,1,0,1,0);
    add(1,0,   0,0, 0,0,0,0,0);
    add(0,1, 351,0, 0,0,0,0,0);
    add(0,1, 351,0, 0,0,0,0,0);
    add(0,1, 351,0, 2,0,0,0,0);
    add(0,0,   0,0, 2,1,0,1,0);
    add(1,0,   0,0, 0,0,0,0,0);
    // alternating ranges never qualify; srdy in IDLE ignored
    for (int k = 0; k < 6; k++)
      add(0,1, (k % 2 == 0) ? 16'd1000 : 16'd2000, 0, 0,0,0,0,0);
    add(0,0,   0,1, 0,0,0,0,0);
    add(0,0,   0,0, 0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].cnt, tbl[i].srdy);
      step();
      chk($sformatf("v%0d freq_mode", i),    32'(bus.freq_mode),    32'(tbl[i].mode));
      chk($sformatf("v%0d drp_start", i),    32'(bus.drp_start),    32'(tbl[i].start));
      chk($sformatf("v%0d data_clk_rdy", i), 32'(bus.data_clk_rdy), 32'(tbl[i].rdy));
      chk($sformatf("v%0d seq_busy", i),     32'(bus.seq_busy),     32'(tbl[i].busy));
      chk($sformatf("v%0d retry_err", i),    32'(bus.retry_err),    32'(tbl[i].err));
    end

`ifdef DRP_SEQ_TIMEOUT_EN
    // No srdy: 4 strobes spaced TIMEOUT_CYC+1 apart, then sticky error.
    do_reset();
    feed3(16'd1000);
    pulses = 0;
    last   = -1;
    for (int c = 0; c < 4 * 4097 + 40; c++) begin
      step();
      if (bus.drp_start === 1'b1) begin
        pulses++;
        if (last >= 0) chk("retry spacing", 32'(c - last), 32'd4097);
        last = c;
      end
    end
    chk("retry pulses", 32'(pulses), 32'd4);
    chk("err retry_err", 32'(bus.retry_err), 32'd1);
    chk("err seq_busy", 32'(bus.seq_busy), 32'd0);
    chk("err data_clk_rdy", 32'(bus.data_clk_rdy), 32'd0);
    drive(1'b0, 1'b0, 16'd0, 1'b1);
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b0);
    step();
    chk("err srdy ignored rdy", 32'(bus.data_clk_rdy), 32'd0);
    chk("err srdy ignored err", 32'(bus.retry_err), 32'd1);
    do_reset();
    chk("err cleared by reset", 32'(bus.retry_err), 32'd0);
`else
    // No srdy: a single strobe, waits forever.
    do_reset();
    feed3(16'd1000);
    pulses = 0;
    for (int c = 0; c < 20000; c++) begin
      step();
      if (bus.drp_start === 1'b1) pulses++;
    end
    chk("no-timeout pulses", 32'(pulses), 32'd1);
    chk("no-timeout seq_busy", 32'(bus.seq_busy), 32'd1);
    chk("no-timeout retry_err", 32'(bus.retry_err), 32'd0);
`endif

    // srdy in the timeout cycle wins: LOCKED, no retry strobe.
    do_reset();
    feed3(16'd2000);
    wait_start("coincident first start");
    for (int c = 0; c < 4096; c++) step();
    drive(1'b0, 1'b0, 16'd0, 1'b1);
    step();
    drive(1'b0, 1'b0, 16'd0, 1'b0);
    chk("coincident rdy", 32'(bus.data_clk_rdy), 32'd1);
    chk("coincident start", 32'(bus.drp_start), 32'd0);
    chk("coincident busy", 32'(bus.seq_busy), 32'd0);
    chk("coincident mode", 32'(bus.freq_mode), 32'd4);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.drp_start === 1'b1) pulses++;
    end
    chk("coincident no retry", 32'(pulses), 32'd0);
    chk("coincident still rdy", 32'(bus.data_clk_rdy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
